// File: rtl/usb_rx_byte_framer_pkg.sv
// Shared definitions for the USB full-speed receive path.
// Holds the line-state and framer-state enums, the default bit timing and
// SYNC pattern, the PID codes used by the downstream packet-control FSM, and
// a helper that classifies a {D+,D-} pair as J, K or SE0.
package usb_rx_byte_framer_pkg;

    typedef enum logic [1:0] {
        J,
        K,
        SE0
    } line_state_t;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        RECEIVE,
        EOP1,
        EOP2,
        ERROR
    } framer_state_t;

    localparam int          CLKS_PER_BIT_DEFAULT = 4;
    localparam int          SAMPLE_PHASE_DEFAULT = 1;
    // KJKJKJKK after NRZI decode, assembled LSB-first.
    localparam logic [7:0]  SYNC_VALUE_DEFAULT   = 8'h80;

    // PID[3:0] codes; the check nibble is the complement of these.
    localparam logic [3:0]  PID_OUT   = 4'b0001;
    localparam logic [3:0]  PID_IN    = 4'b1001;
    localparam logic [3:0]  PID_SOF   = 4'b0101;
    localparam logic [3:0]  PID_SETUP = 4'b1101;
    localparam logic [3:0]  PID_DATA0 = 4'b0011;
    localparam logic [3:0]  PID_DATA1 = 4'b1011;
    localparam logic [3:0]  PID_ACK   = 4'b0010;
    localparam logic [3:0]  PID_NAK   = 4'b1010;
    localparam logic [3:0]  PID_STALL = 4'b1110;

    // Both-high is illegal on the bus; fold it into SE0.
    function automatic line_state_t decode_line(input logic dp, input logic dm);
        if (dp && !dm)
            return J;
        else if (!dp && dm)
            return K;
        else
            return SE0;
    endfunction

endpackage

// File: rtl/usb_rx_byte_framer_if.sv
// Bus between the synchronized USB line / downstream packet FSM and the framer.
// Signals:
//   d_plus, d_minus   synchronized line inputs (driven by master)
//   sync_byte         1-clk pulse, SYNC found
//   packet_in[7:0]    last complete byte, held
//   byte_count        1-clk pulse, packet_in updated
//   eop               1-clk pulse, end of packet
//   crc_bit/crc_shift decoded body bit and its qualifier for CRC checkers
//   rx_error          1-clk pulse, framing/stuffing error
//   receiving         level, packet in progress
// Handshake: no back-pressure. Every pulse output is valid for exactly the one
// clock it is high and must be consumed in that clock; packet_in and crc_bit
// are data qualified by byte_count and crc_shift respectively.
interface usb_rx_byte_framer_if;
    logic       d_plus;
    logic       d_minus;
    logic       sync_byte;
    logic [7:0] packet_in;
    logic       byte_count;
    logic       eop;
    logic       crc_bit;
    logic       crc_shift;
    logic       rx_error;
    logic       receiving;

    modport master (
        output d_plus, d_minus,
        input  sync_byte, packet_in, byte_count, eop, crc_bit, crc_shift,
               rx_error, receiving
    );

    modport slave (
        input  d_plus, d_minus,
        output sync_byte, packet_in, byte_count, eop, crc_bit, crc_shift,
               rx_error, receiving
    );
endinterface

// File: rtl/usb_rx_byte_framer_bit_sampler.sv
// Bit-timing recovery and NRZI decode.
// Ports:
//   clk, n_rst      clock, async active-low reset
//   d_plus_i        synchronized D+
//   d_minus_i       synchronized D-
//   force_j_i       hold the NRZI reference at J (framer is idle)
//   sample_o        strobe: line is sampled this clock
//   line_o          J/K/SE0 classification of the current line
//   nrzi_bit_o      decoded bit (valid when sample_o and line_o != SE0)
module usb_rx_byte_framer_bit_sampler
    import usb_rx_byte_framer_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int SAMPLE_PHASE = SAMPLE_PHASE_DEFAULT
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        d_plus_i,
    input  logic        d_minus_i,
    input  logic        force_j_i,
    output logic        sample_o,
    output line_state_t line_o,
    output logic        nrzi_bit_o
);
    localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic          dp_q;
    logic [PW-1:0] phase_q, phase_d;
    logic          prev_q, prev_d;
    logic          dp_edge;

    always_comb begin
        dp_edge    = d_plus_i ^ dp_q;
        phase_d    = phase_q + 1'b1;
        if (dp_edge || phase_q == PW'(CLKS_PER_BIT - 1))
            phase_d = '0;
        // An edge in the sample slot would otherwise sample the new bit at
        // its very first clock and again after the realignment.
        sample_o   = (phase_q == PW'(SAMPLE_PHASE)) && !dp_edge;
        line_o     = decode_line(d_plus_i, d_minus_i);
        nrzi_bit_o = (d_plus_i == prev_q);
        prev_d     = prev_q;
        // A real J/K sample wins over the idle force so the first K of SYNC
        // becomes the reference for the next bit.
        if (sample_o && line_o != SE0)
            prev_d = d_plus_i;
        else if (force_j_i)
            prev_d = 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_q    <= 1'b1;
            phase_q <= '0;
            prev_q  <= 1'b1;
        end else begin
            dp_q    <= d_plus_i;
            phase_q <= phase_d;
            prev_q  <= prev_d;
        end
    end
endmodule

// File: rtl/usb_rx_byte_framer.sv
// USB RX byte framer: bit stuffing removal, SYNC hunt, LSB-first byte assembly
// and EOP detection on top of the bit sampler.
// Ports:
//   clk, n_rst   clock, async active-low reset
//   bus          slave side of usb_rx_byte_framer_if (line in, framer outputs)
//   state_o      current framer state, for observation
module usb_rx_byte_framer
    import usb_rx_byte_framer_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int         SAMPLE_PHASE = SAMPLE_PHASE_DEFAULT,
    parameter logic [7:0] SYNC_VALUE   = SYNC_VALUE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 n_rst,
    usb_rx_byte_framer_if.slave  bus,
    output framer_state_t        state_o
);
    logic        sample;
    line_state_t line;
    logic        nrzi_bit;

    framer_state_t state_q, state_d;
    logic [7:0]    sr_q, sr_d, shifted;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    ones_cnt_q, ones_cnt_d;
    logic          se0_seen_q, se0_seen_d;
    logic [7:0]    packet_q, packet_d;
    logic          crc_bit_q, crc_bit_d;
    logic          recv_q, recv_d;
    logic          sync_q, sync_d;
    logic          byte_q, byte_d;
    logic          eop_q, eop_d;
    logic          crc_shift_q, crc_shift_d;
    logic          err_q, err_d;

    usb_rx_byte_framer_bit_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_PHASE (SAMPLE_PHASE)
    ) u_sampler (
        .clk        (clk),
        .n_rst      (n_rst),
        .d_plus_i   (bus.d_plus),
        .d_minus_i  (bus.d_minus),
        .force_j_i  (state_q == IDLE),
        .sample_o   (sample),
        .line_o     (line),
        .nrzi_bit_o (nrzi_bit)
    );

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        bit_cnt_d   = bit_cnt_q;
        ones_cnt_d  = ones_cnt_q;
        se0_seen_d  = se0_seen_q;
        packet_d    = packet_q;
        crc_bit_d   = crc_bit_q;
        recv_d      = recv_q;
        sync_d      = 1'b0;
        byte_d      = 1'b0;
        eop_d       = 1'b0;
        crc_shift_d = 1'b0;
        err_d       = 1'b0;
        shifted     = {nrzi_bit, sr_q[7:1]};

        if (sample) begin
            case (state_q)
                IDLE: begin
                    // The first K decodes to 0, so a cleared register already
                    // holds it as the first SYNC bit.
                    sr_d       = '0;
                    bit_cnt_d  = '0;
                    ones_cnt_d = '0;
                    if (line == K)
                        state_d = HUNT;
                end
                HUNT: begin
                    if (line == SE0) begin
                        state_d = IDLE;
                        recv_d  = 1'b0;
                    end else begin
                        sr_d = shifted;
                        if (shifted == SYNC_VALUE) begin
                            sync_d     = 1'b1;
                            recv_d     = 1'b1;
                            bit_cnt_d  = '0;
                            ones_cnt_d = '0;
                            state_d    = RECEIVE;
                        end
                    end
                end
                RECEIVE: begin
                    if (line == SE0) begin
                        state_d = EOP1;
                    end else if (ones_cnt_q == 3'd6) begin
                        // Bit after six 1s must be a stuffed 0.
                        if (nrzi_bit) begin
                            err_d      = 1'b1;
                            se0_seen_d = 1'b0;
                            state_d    = ERROR;
                        end else begin
                            ones_cnt_d = '0;
                        end
                    end else begin
                        sr_d        = shifted;
                        crc_shift_d = 1'b1;
                        crc_bit_d   = nrzi_bit;
                        ones_cnt_d  = nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            packet_d = shifted;
                            byte_d   = 1'b1;
                        end
                    end
                end
                EOP1: begin
                    if (line == SE0) begin
                        state_d = EOP2;
                    end else begin
                        err_d      = 1'b1;
                        se0_seen_d = 1'b0;
                        state_d    = ERROR;
                    end
                end
                EOP2: begin
                    if (line == J) begin
                        eop_d   = 1'b1;
                        recv_d  = 1'b0;
                        err_d   = (bit_cnt_q != 3'd0);
                        state_d = IDLE;
                    end else if (line == K) begin
                        err_d      = 1'b1;
                        se0_seen_d = 1'b0;
                        state_d    = ERROR;
                    end
                end
                ERROR: begin
                    if (line == SE0) begin
                        se0_seen_d = 1'b1;
                    end else if (line == J && se0_seen_q) begin
                        eop_d   = 1'b1;
                        recv_d  = 1'b0;
                        state_d = IDLE;
                    end else if (line == K) begin
                        se0_seen_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            ones_cnt_q  <= '0;
            se0_seen_q  <= 1'b0;
            packet_q    <= 8'h00;
            crc_bit_q   <= 1'b0;
            recv_q      <= 1'b0;
            sync_q      <= 1'b0;
            byte_q      <= 1'b0;
            eop_q       <= 1'b0;
            crc_shift_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            bit_cnt_q   <= bit_cnt_d;
            ones_cnt_q  <= ones_cnt_d;
            se0_seen_q  <= se0_seen_d;
            packet_q    <= packet_d;
            crc_bit_q   <= crc_bit_d;
            recv_q      <= recv_d;
            sync_q      <= sync_d;
            byte_q      <= byte_d;
            eop_q       <= eop_d;
            crc_shift_q <= crc_shift_d;
            err_q       <= err_d;
        end
    end

    assign bus.sync_byte  = sync_q;
    assign bus.packet_in  = packet_q;
    assign bus.byte_count = byte_q;
    assign bus.eop        = eop_q;
    assign bus.crc_bit    = crc_bit_q;
    assign bus.crc_shift  = crc_shift_q;
    assign bus.rx_error   = err_q;
    assign bus.receiving  = recv_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_usb_rx_byte_framer.sv
module tb_usb_rx_byte_framer;
    import usb_rx_byte_framer_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    usb_rx_byte_framer_if bus();
    framer_state_t state_dbg;

    usb_rx_byte_framer dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .bus     (bus),
        .state_o (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [0:0] exp_crc_q[$];
    logic [0:0] obs_crc_q[$];

    int exp_sync = 0, exp_eop = 0, exp_err = 0, exp_eop_err = 0;
    int sync_n = 0, eop_n = 0, err_n = 0, eop_err_n = 0, eop_fall_n = 0;
    logic recv_prev = 1'b0;

    int   bit_w     = 4;
    logic jitter    = 1'b0;
    logic jit_phase = 1'b0;
    logic level     = 1'b1;
    int   ones      = 0;

    // Output monitor: records what the DUT produces, away from the active edge.
    always @(negedge clk) begin
        if (bus.byte_count) obs_q.push_back(bus.packet_in);
        if (bus.crc_shift)  obs_crc_q.push_back(bus.crc_bit);
        if (bus.sync_byte)  sync_n++;
        if (bus.rx_error)   err_n++;
        if (bus.eop) begin
            eop_n++;
            if (bus.rx_error) eop_err_n++;
            if (recv_prev && !bus.receiving) eop_fall_n++;
        end
        recv_prev = bus.receiving;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_line(input logic dp, input logic dm, input int n);
        bus.d_plus  = dp;
        bus.d_minus = dm;
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_width(output int w);
        if (jitter) begin
            jit_phase = ~jit_phase;
            w = jit_phase ? 3 : 5;
        end else begin
            w = bit_w;
        end
    endtask

    task automatic send_level(input logic lv);
        int w;
        bit_width(w);
        drive_line(lv, ~lv, w);
    endtask

    // NRZI: a 0 toggles the line, a 1 holds it.
    task automatic send_raw(input logic b);
        if (!b) level = ~level;
        send_level(level);
    endtask

    task automatic send_sync();
        for (int i = 0; i < 7; i++) send_raw(1'b0);
        send_raw(1'b1);
        ones = 0;
        exp_sync++;
    endtask

    task automatic send_body_bit(input logic b, input logic stuff);
        exp_crc_q.push_back(b);
        send_raw(b);
        if (b) ones++; else ones = 0;
        if (stuff && ones == 6) begin
            send_raw(1'b0);
            ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        exp_q.push_back(v);
        for (int i = 0; i < 8; i++) send_body_bit(v[i], 1'b1);
    endtask

    task automatic send_se0_bit();
        int w;
        bit_width(w);
        drive_line(1'b0, 1'b0, w);
    endtask

    task automatic send_eop();
        send_se0_bit();
        send_se0_bit();
        level = 1'b1;
        send_level(1'b1);
        exp_eop++;
    endtask

    task automatic idle(input int n);
        level = 1'b1;
        drive_line(1'b1, 1'b0, n);
    endtask

    // Drain the scoreboard and compare event counts for one packet.
    task automatic end_pkt(input string tag);
        check({tag, "/byte_count_n"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "/packet_in"}, obs_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        obs_q.delete();
        check({tag, "/crc_shift_n"}, obs_crc_q.size(), exp_crc_q.size());
        while (exp_crc_q.size() > 0 && obs_crc_q.size() > 0)
            check({tag, "/crc_bit"}, obs_crc_q.pop_front(), exp_crc_q.pop_front());
        exp_crc_q.delete();
        obs_crc_q.delete();
        check({tag, "/sync_n"}, sync_n, exp_sync);
        check({tag, "/eop_n"}, eop_n, exp_eop);
        check({tag, "/err_n"}, err_n, exp_err);
        check({tag, "/eop_with_err_n"}, eop_err_n, exp_eop_err);
        check({tag, "/receiving_falls_at_eop"}, eop_fall_n, exp_eop);
        check({tag, "/receiving"}, bus.receiving, 1'b0);
        check({tag, "/state"}, state_dbg, IDLE);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_rst = 1'b0;
        bus.d_plus  = 1'b1;
        bus.d_minus = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/packet_in", bus.packet_in, 8'h00);
        check("reset/pulses", {bus.sync_byte, bus.byte_count, bus.eop, bus.crc_shift, bus.rx_error}, 5'b0);
        check("reset/receiving", bus.receiving, 1'b0);
        check("reset/state", state_dbg, IDLE);
        n_rst = 1'b1;
        idle(20);

        // Basic packet.
        send_sync();
        check("t1/receiving_after_sync", bus.receiving, 1'b1);
        send_byte(8'h2D);
        send_eop();
        idle(16);
        end_pkt("t1");

        // Stuffed 0 inside 8'hFF, then 8'h00.
        send_sync();
        send_byte(8'hFF);
        send_byte(8'h00);
        send_eop();
        idle(16);
        end_pkt("t2");

        // Seven 1s without a stuff bit.
        send_sync();
        for (int i = 0; i < 6; i++) send_body_bit(1'b1, 1'b0);
        send_raw(1'b1);
        exp_err++;
        check("t3/state_error", state_dbg, ERROR);
        send_eop();
        idle(16);
        end_pkt("t3");

        // Partial byte at EOP.
        send_sync();
        send_byte(8'hA5);
        send_body_bit(1'b1, 1'b1);
        send_body_bit(1'b1, 1'b1);
        send_body_bit(1'b0, 1'b1);
        send_eop();
        exp_err++;
        exp_eop_err++;
        idle(16);
        end_pkt("t4");

        // Single SE0 mid-byte followed by K.
        send_sync();
        send_body_bit(1'b1, 1'b1);
        send_body_bit(1'b0, 1'b1);
        send_body_bit(1'b1, 1'b1);
        send_body_bit(1'b1, 1'b1);
        send_se0_bit();
        level = 1'b0;
        send_level(1'b0);
        exp_err++;
        check("t5/state_error", state_dbg, ERROR);
        check("t5/receiving_in_error", bus.receiving, 1'b1);
        send_eop();
        idle(16);
        end_pkt("t5");

        // Bit period alternating 3/5 clocks.
        jitter    = 1'b1;
        jit_phase = 1'b0;
        send_sync();
        send_byte(8'h96);
        send_eop();
        jitter = 1'b0;
        idle(16);
        end_pkt("t6");

        // Reset in the middle of a byte.
        send_sync();
        send_body_bit(1'b1, 1'b1);
        send_body_bit(1'b0, 1'b1);
        send_body_bit(1'b0, 1'b1);
        send_body_bit(1'b1, 1'b1);
        n_rst = 1'b0;
        bus.d_plus  = 1'b1;
        bus.d_minus = 1'b0;
        @(negedge clk);
        check("t7/reset_packet_in", bus.packet_in, 8'h00);
        check("t7/reset_pulses", {bus.sync_byte, bus.byte_count, bus.eop, bus.crc_shift, bus.rx_error, bus.crc_bit}, 6'b0);
        check("t7/reset_receiving", bus.receiving, 1'b0);
        check("t7/reset_state", state_dbg, IDLE);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        idle(20);
        end_pkt("t7");

        // Normal reception after the mid-packet reset.
        send_sync();
        send_byte(8'h3C);
        send_eop();
        idle(16);
        end_pkt("t8");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
